// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer and its iterative engine.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [4:0]  OP_MUL  = 5'b00110;
    localparam logic [4:0]  OP_DIV  = 5'b00111;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/multdiv_engine.sv
// Iterative datapath: radix-2 shift-add multiply and restoring divide, one step per cycle.
// With MULTDIV_BOOTH_EN defined, multiply instead uses signed radix-4 Booth, two bits per step.
module multdiv_engine
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               init,
    input  logic               step,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quot
);

    logic             div_r;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] sub;
    logic             ge;

    // Divide: hi is the running remainder, lo shifts the dividend out and the quotient in.
    always_comb begin
        shifted = {hi, lo[WIDTH-1]};
        ge      = shifted >= {1'b0, opnd};
        sub     = shifted[WIDTH-1:0] - opnd;
    end

`ifdef MULTDIV_BOOTH_EN
    logic [WIDTH+1:0] bhi;
    logic [WIDTH+1:0] bmc;
    logic [WIDTH+1:0] bsum;
    logic             bx;

    always_comb begin
        bmc = '0;
        case ({lo[1:0], bx})
            3'b001, 3'b010: bmc = {{2{opnd[WIDTH-1]}}, opnd};
            3'b011:         bmc = {opnd[WIDTH-1], opnd, 1'b0};
            3'b100:         bmc = -{opnd[WIDTH-1], opnd, 1'b0};
            3'b101, 3'b110: bmc = -{{2{opnd[WIDTH-1]}}, opnd};
            default:        bmc = '0;
        endcase
        bsum = bhi + bmc;
    end

    assign prod = {bhi[WIDTH-1:0], lo};
`else
    logic [WIDTH:0] add_sum;

    always_comb begin
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    end

    assign prod = {hi, lo};
`endif

    assign quot = lo;

    always_ff @(posedge clock) begin
        if (init) begin
            div_r <= div_mode;
            hi    <= '0;
            lo    <= div_mode ? a : b;
            opnd  <= div_mode ? b : a;
`ifdef MULTDIV_BOOTH_EN
            bhi   <= '0;
            bx    <= 1'b0;
`endif
        end else if (step) begin
            if (div_r) begin
                if (ge) begin
                    hi <= sub;
                    lo <= {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi <= shifted[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b0};
                end
            end else begin
`ifdef MULTDIV_BOOTH_EN
                bhi <= {{2{bsum[WIDTH+1]}}, bsum[WIDTH+1:2]};
                lo  <= {bsum[1:0], lo[WIDTH-1:2]};
                bx  <= lo[1];
`else
                {hi, lo} <= {add_sum, lo[WIDTH-1:1]};
`endif
            end
        end
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multiply/divide engine: FSM, pipeline stall, sign and exception handling.
// Optional MULTDIV_BOOTH_EN: radix-4 Booth multiply, latency WIDTH/2+1 instead of WIDTH+1.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [4:0]       dest_in,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             result_rdy,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       dest_out,
    output logic             exception
);

`ifdef MULTDIV_BOOTH_EN
    localparam bit BOOTH = 1'b1;
`else
    localparam bit BOOTH = 1'b0;
`endif
    localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(WIDTH / 2 - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   last_cnt;
    logic               div_r;
    logic               neg_r;
    logic               div0_r;
    logic               min_ovf_r;
    logic [4:0]         dest_r;
    logic               take_mult;
    logic               take_div;
    logic               take;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   eng_a;
    logic [WIDTH-1:0]   eng_b;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   quot_s;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic               mul_ovf;
    logic [WIDTH-1:0]   fin_result;
    logic               fin_exc;

    // The Booth engine multiplies signed operands directly, so only radix-2 paths use magnitudes.
    always_comb begin
        take_mult = (state == IDLE || state == DONE) && !flush && start_mult;
        take_div  = (state == IDLE || state == DONE) && !flush && start_div && !start_mult;
        take      = take_mult || take_div;
        a_mag     = operand_a[WIDTH-1] ? -operand_a : operand_a;
        b_mag     = operand_b[WIDTH-1] ? -operand_b : operand_b;
        eng_a     = (take_mult && BOOTH) ? operand_a : a_mag;
        eng_b     = (take_mult && BOOTH) ? operand_b : b_mag;
        last_cnt  = (state == MULT && BOOTH) ? LAST_HALF : LAST_FULL;
        prod_s    = neg_r ? -prod : prod;
        quot_s    = neg_r ? -quot : quot;
        mul_ovf   = prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};
        if (div_r) begin
            fin_result = div0_r ? '0 : quot_s;
            fin_exc    = div0_r || min_ovf_r;
        end else begin
            fin_result = mul_ovf ? '0 : prod_s[WIDTH-1:0];
            fin_exc    = mul_ovf;
        end
    end

    assign busy  = (state == MULT) || (state == DIV);
    assign stall = ((start_mult || start_div) && state == IDLE) || busy;

    multdiv_engine #(.WIDTH(WIDTH)) engine (
        .clock    (clock),
        .init     (take),
        .step     (busy),
        .div_mode (take_div),
        .a        (eng_a),
        .b        (eng_b),
        .prod     (prod),
        .quot     (quot)
    );

    // A start accepted in DONE overrides the return to IDLE, giving back-to-back issue.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            result_rdy <= 1'b0;
            result     <= '0;
            dest_out   <= '0;
            exception  <= 1'b0;
            div_r      <= 1'b0;
            neg_r      <= 1'b0;
            div0_r     <= 1'b0;
            min_ovf_r  <= 1'b0;
            dest_r     <= '0;
        end else begin
            result_rdy <= 1'b0;
            case (state)
                MULT, DIV: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (count == last_cnt) begin
                        state <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    result_rdy <= 1'b1;
                    result     <= fin_result;
                    exception  <= fin_exc;
                    dest_out   <= dest_r;
                    state      <= IDLE;
                end
                default: ;
            endcase
            if (take) begin
                count     <= '0;
                div_r     <= take_div;
                dest_r    <= dest_in;
                neg_r     <= (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]) && !(take_mult && BOOTH);
                div0_r    <= take_div && (operand_b == '0);
                min_ovf_r <= take_div && (operand_a == MIN_VAL) && (operand_b == '1);
                if (take_div && operand_b == '0) begin
                    state <= DONE;
                end else begin
                    state <= take_mult ? MULT : DIV;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl against an arithmetic reference model.
// Honours MULTDIV_BOOTH_EN for the expected multiply latency.
module tb_multdiv_ctrl;
    import multdiv_pkg::*;

    localparam int WIDTH = 32;
`ifdef MULTDIV_BOOTH_EN
    localparam int MULT_LAT = WIDTH / 2 + 1;
`else
    localparam int MULT_LAT = WIDTH + 1;
`endif
    localparam int DIV_LAT = WIDTH + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [4:0]  dest_in = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        busy;
    logic        result_rdy;
    logic [31:0] result;
    logic [4:0]  dest_out;
    logic        exception;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    multdiv_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .dest_in    (dest_in),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy),
        .result_rdy (result_rdy),
        .result     (result),
        .dest_out   (dest_out),
        .exception  (exception)
    );

    // Reference: signed 64-bit product, truncating signed division, with the exception rules.
    function automatic void ref_model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic e);
        longint p;
        int q;
        if (is_mult) begin
            p = longint'($signed(a)) * longint'($signed(b));
            if (p != longint'(int'(p))) begin
                r = '0;
                e = 1'b1;
            end else begin
                r = 32'(p);
                e = 1'b0;
            end
        end else if (b == 32'd0) begin
            r = '0;
            e = 1'b1;
        end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
            r = INT_MIN;
            e = 1'b1;
        end else begin
            q = int'($signed(a)) / int'($signed(b));
            r = 32'(q);
            e = 1'b0;
        end
    endfunction

    function automatic int ref_latency(input bit is_mult, input logic [31:0] b);
        if (is_mult) return MULT_LAT;
        if (b == 32'd0) return 1;
        return DIV_LAT;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'($urandom);
            1: return 32'($urandom_range(0, 200)) - 32'd100;
            2: return INT_MIN;
            3: return 32'hFFFF_FFFF;
            4: return 32'd0;
            default: return {16'h0000, 16'($urandom)};
        endcase
    endfunction

    // Issues one op and waits (bounded) for its result pulse; lat = -1 on timeout.
    task automatic run_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] dest, output int lat, output logic [31:0] res,
                          output logic exc, output logic [4:0] dout, output int stall_cnt,
                          output bit stall_issue);
        start_mult = is_mult;
        start_div  = !is_mult;
        operand_a  = a;
        operand_b  = b;
        dest_in    = dest;
        #1 stall_issue = stall;
        @(posedge clock); #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        stall_cnt  = stall ? 1 : 0;
        lat  = -1;
        res  = 'x;
        exc  = 1'bx;
        dout = 'x;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clock); #1;
            if (result_rdy) begin
                lat  = n;
                res  = result;
                exc  = exception;
                dout = dest_out;
                break;
            end
            if (stall) stall_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (result_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rdy: got %b want 0", result_rdy); end
        vectors++; if (result !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_result: got %h want 0", result); end
        vectors++; if (dest_out !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_dest: got %h want 0", dest_out); end
        vectors++; if (exception !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_exc: got %b want 0", exception); end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_mult_basic();
        int lat, sc; logic [31:0] res; logic exc; logic [4:0] d; bit si;
        run_op(1'b1, 32'd7, -32'sd3, 5'd4, lat, res, exc, d, sc, si);
        vectors++; if (lat != MULT_LAT) begin miscompares++; $display("[TB] FAIL mult_latency: got %0d want %0d", lat, MULT_LAT); end
        vectors++; if (res !== 32'hFFFF_FFEB) begin miscompares++; $display("[TB] FAIL mult_result: got %h want ffffffeb", res); end
        vectors++; if (exc !== 1'b0) begin miscompares++; $display("[TB] FAIL mult_exc: got %b want 0", exc); end
        vectors++; if (d !== 5'd4) begin miscompares++; $display("[TB] FAIL mult_dest: got %0d want 4", d); end
        vectors++; if (si !== 1'b1) begin miscompares++; $display("[TB] FAIL mult_stall_issue: got %b want 1", si); end
        vectors++; if (sc != MULT_LAT - 1) begin miscompares++; $display("[TB] FAIL mult_stall_cycles: got %0d want %0d", sc, MULT_LAT - 1); end
    endtask

    task automatic test_div_basic();
        int lat, sc; logic [31:0] res; logic exc; logic [4:0] d; bit si;
        run_op(1'b0, -32'sd100, 32'd7, 5'd9, lat, res, exc, d, sc, si);
        vectors++; if (lat != DIV_LAT) begin miscompares++; $display("[TB] FAIL div_latency: got %0d want %0d", lat, DIV_LAT); end
        vectors++; if (res !== 32'hFFFF_FFF2) begin miscompares++; $display("[TB] FAIL div_neg_result: got %h want fffffff2", res); end
        vectors++; if (exc !== 1'b0) begin miscompares++; $display("[TB] FAIL div_neg_exc: got %b want 0", exc); end
        vectors++; if (d !== 5'd9) begin miscompares++; $display("[TB] FAIL div_dest: got %0d want 9", d); end
        run_op(1'b0, 32'd100, 32'd7, 5'd9, lat, res, exc, d, sc, si);
        vectors++; if (res !== 32'd14) begin miscompares++; $display("[TB] FAIL div_pos_result: got %h want 0000000e", res); end
        vectors++; if (sc != DIV_LAT - 1) begin miscompares++; $display("[TB] FAIL div_stall_cycles: got %0d want %0d", sc, DIV_LAT - 1); end
    endtask

    task automatic test_div_zero();
        int lat, sc; logic [31:0] res; logic exc; logic [4:0] d; bit si;
        run_op(1'b0, 32'd5, 32'd0, 5'd12, lat, res, exc, d, sc, si);
        vectors++; if (lat != 1) begin miscompares++; $display("[TB] FAIL div0_latency: got %0d want 1", lat); end
        vectors++; if (res !== 32'd0) begin miscompares++; $display("[TB] FAIL div0_result: got %h want 0", res); end
        vectors++; if (exc !== 1'b1) begin miscompares++; $display("[TB] FAIL div0_exc: got %b want 1", exc); end
        vectors++; if (sc != 0) begin miscompares++; $display("[TB] FAIL div0_stall_cycles: got %0d want 0", sc); end
        repeat (3) begin @(posedge clock); #1; end
        vectors++; if (result_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL rdy_pulse: got %b want 0", result_rdy); end
        vectors++; if (exception !== 1'b1 || dest_out !== 5'd12) begin
            miscompares++; $display("[TB] FAIL hold_outputs: got exc %b dest %0d want exc 1 dest 12", exception, dest_out);
        end
    endtask

    task automatic test_overflow();
        int lat, sc; logic [31:0] res; logic exc; logic [4:0] d; bit si;
        run_op(1'b1, 32'h0001_0000, 32'h0001_0000, 5'd1, lat, res, exc, d, sc, si);
        vectors++; if (res !== 32'd0 || exc !== 1'b1) begin miscompares++; $display("[TB] FAIL mult_ovf: got %h/%b want 00000000/1", res, exc); end
        run_op(1'b0, INT_MIN, 32'hFFFF_FFFF, 5'd2, lat, res, exc, d, sc, si);
        vectors++; if (res !== INT_MIN || exc !== 1'b1) begin miscompares++; $display("[TB] FAIL div_min_neg1: got %h/%b want 80000000/1", res, exc); end
        run_op(1'b1, INT_MIN, 32'd1, 5'd3, lat, res, exc, d, sc, si);
        vectors++; if (res !== INT_MIN || exc !== 1'b0) begin miscompares++; $display("[TB] FAIL mult_min_one: got %h/%b want 80000000/0", res, exc); end
        run_op(1'b1, INT_MIN, 32'hFFFF_FFFF, 5'd3, lat, res, exc, d, sc, si);
        vectors++; if (res !== 32'd0 || exc !== 1'b1) begin miscompares++; $display("[TB] FAIL mult_min_neg1: got %h/%b want 00000000/1", res, exc); end
    endtask

    task automatic test_flush();
        int rdy_seen, lat, sc; logic [31:0] res; logic exc; logic [4:0] d; bit si;
        start_div = 1'b1; operand_a = 32'd1000; operand_b = 32'd3; dest_in = 5'd7;
        @(posedge clock); #1;
        start_div = 1'b0;
        repeat (9) begin @(posedge clock); #1; end
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        vectors++; if (stall !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_stall: got stall %b busy %b want 0 0", stall, busy); end
        rdy_seen = result_rdy ? 1 : 0;
        repeat (2 * WIDTH) begin @(posedge clock); #1; if (result_rdy) rdy_seen++; end
        vectors++; if (rdy_seen != 0) begin miscompares++; $display("[TB] FAIL flush_no_result: got %0d pulses want 0", rdy_seen); end
        start_mult = 1'b1; flush = 1'b1; operand_a = 32'd3; operand_b = 32'd3;
        @(posedge clock); #1;
        start_mult = 1'b0; flush = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_start_ignored: got busy %b want 0", busy); end
        rdy_seen = 0;
        repeat (2 * WIDTH) begin @(posedge clock); #1; if (result_rdy) rdy_seen++; end
        vectors++; if (rdy_seen != 0) begin miscompares++; $display("[TB] FAIL flush_start_no_result: got %0d pulses want 0", rdy_seen); end
        run_op(1'b1, 32'd6, 32'd7, 5'd11, lat, res, exc, d, sc, si);
        vectors++; if (lat != MULT_LAT || res !== 32'd42 || exc !== 1'b0) begin
            miscompares++; $display("[TB] FAIL post_flush_mult: got lat %0d res %h exc %b want %0d 0000002a 0", lat, res, exc, MULT_LAT);
        end
    endtask

    task automatic test_reset_midop();
        int rdy_seen;
        start_mult = 1'b1; operand_a = 32'd123; operand_b = 32'd456; dest_in = 5'd2;
        @(posedge clock); #1;
        start_mult = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        reset = 1'b0;
        @(posedge clock); #1;
        vectors++; if (stall !== 1'b0 || busy !== 1'b0 || result_rdy !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midop_reset_ctrl: got stall %b busy %b rdy %b want 0 0 0", stall, busy, result_rdy);
        end
        vectors++; if (result !== 32'd0 || dest_out !== 5'd0 || exception !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midop_reset_data: got %h/%0d/%b want 0/0/0", result, dest_out, exception);
        end
        reset = 1'b1;
        rdy_seen = 0;
        repeat (2 * WIDTH) begin @(posedge clock); #1; if (result_rdy) rdy_seen++; end
        vectors++; if (rdy_seen != 0) begin miscompares++; $display("[TB] FAIL midop_reset_abandon: got %0d pulses want 0", rdy_seen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp1, exp2; logic e1, e2;
        int n, lat2;
        ref_model(1'b1, 32'd1234, -32'sd5678, exp1, e1);
        ref_model(1'b0, -32'sd1000, 32'd7, exp2, e2);
        start_mult = 1'b1; operand_a = 32'd1234; operand_b = -32'sd5678; dest_in = 5'd1;
        @(posedge clock); #1;
        start_mult = 1'b0;
        n = 0;
        while (stall && n < 200) begin @(posedge clock); #1; n++; end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_wait_done: got stall %b want 0", stall); end
        start_div = 1'b1; operand_a = -32'sd1000; operand_b = 32'd7; dest_in = 5'd3;
        @(posedge clock); #1;
        start_div = 1'b0;
        vectors++; if (result_rdy !== 1'b1 || result !== exp1 || exception !== e1 || dest_out !== 5'd1) begin
            miscompares++; $display("[TB] FAIL b2b_first: got rdy %b %h/%b/%0d want 1 %h/%b/1", result_rdy, result, exception, dest_out, exp1, e1);
        end
        lat2 = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clock); #1;
            if (result_rdy) begin lat2 = k; break; end
        end
        vectors++; if (lat2 != DIV_LAT) begin miscompares++; $display("[TB] FAIL b2b_latency: got %0d want %0d", lat2, DIV_LAT); end
        vectors++; if (result !== exp2 || exception !== e2 || dest_out !== 5'd3) begin
            miscompares++; $display("[TB] FAIL b2b_second: got %h/%b/%0d want %h/%b/3", result, exception, dest_out, exp2, e2);
        end
    endtask

    task automatic test_random(input int count);
        int lat, sc; logic [31:0] res, a, b, exp_r; logic exc, exp_e; logic [4:0] d, dest; bit si, is_mult;
        logic [4:0] op;
        for (int i = 0; i < count; i++) begin
            op      = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
            is_mult = (op == OP_MUL);
            a       = rand_operand();
            b       = rand_operand();
            dest    = 5'($urandom_range(0, 31));
            ref_model(is_mult, a, b, exp_r, exp_e);
            run_op(is_mult, a, b, dest, lat, res, exc, d, sc, si);
            vectors++; if (res !== exp_r) begin miscompares++; $display("[TB] FAIL rand_result op=%b a=%h b=%h: got %h want %h", op, a, b, res, exp_r); end
            vectors++; if (exc !== exp_e) begin miscompares++; $display("[TB] FAIL rand_exc op=%b a=%h b=%h: got %b want %b", op, a, b, exc, exp_e); end
            vectors++; if (d !== dest) begin miscompares++; $display("[TB] FAIL rand_dest: got %0d want %0d", d, dest); end
            vectors++; if (lat != ref_latency(is_mult, b)) begin
                miscompares++; $display("[TB] FAIL rand_latency op=%b b=%h: got %0d want %0d", op, b, lat, ref_latency(is_mult, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_div_basic();
        test_div_zero();
        test_overflow();
        test_flush();
        test_reset_midop();
        test_back_to_back();
        test_random(40);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
